// File: rtl/pipeline_chain.sv
`default_nettype none
// ============================================================================
// pipeline_chain : elastic DEPTH-stage register chain with valid/ready, stall,
//                  per-stage flush, bubble collapse and a saturating squash count
// Revision: 1.0
// ============================================================================
module pipeline_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         stall,
   input  logic [DEPTH-1:0]             flush_mask,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             squash_count
);

   localparam int OCC_W = $clog2(DEPTH+1);
   localparam int SUM_W = CNT_W + 1;

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [DEPTH-1:0] w_ve;
   logic [DEPTH-1:0] w_adv;
   logic [DEPTH-1:0] w_load;
   logic [DEPTH-1:0] w_nxt_valid;
   logic             w_accept;
   logic [OCC_W-1:0] w_occ_nxt;
   logic [OCC_W-1:0] w_kills;
   logic [SUM_W-1:0] w_sq_sum;

   always_comb begin
      w_ve      = r_valid & ~flush_mask;
      out_valid = w_ve[DEPTH-1] & ~stall;
      w_adv     = '0;
      w_adv[DEPTH-1] = out_valid & out_ready;
      // Advance resolves from the output end so a vacating stage lets its predecessor move.
      for (int i = DEPTH-2; i >= 0; i--) begin
         w_adv[i] = w_ve[i] & ~stall & (~w_ve[i+1] | w_adv[i+1]);
      end
      in_ready = ~stall & (~w_ve[0] | w_adv[0]);
      w_accept = in_valid & in_ready;

      w_load    = '0;
      w_load[0] = w_accept;
      for (int i = 1; i < DEPTH; i++) begin
         w_load[i] = w_adv[i-1];
      end
      w_nxt_valid = w_load | (w_ve & ~w_adv);

      w_occ_nxt = '0;
      w_kills   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ_nxt = w_occ_nxt + OCC_W'(w_nxt_valid[i]);
         w_kills   = w_kills + OCC_W'(flush_mask[i] & r_valid[i]);
      end
      w_sq_sum = {1'b0, squash_count} + SUM_W'(w_kills);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid      <= '0;
         occupancy    <= '0;
         squash_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid      <= w_nxt_valid;
         occupancy    <= w_occ_nxt;
         squash_count <= w_sq_sum[CNT_W] ? {CNT_W{1'b1}} : w_sq_sum[CNT_W-1:0];
         // Data only changes on a load; otherwise it holds even when the stage empties.
         if (w_load[0]) begin
            r_data[0] <= in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_load[i]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign stage_valid = r_valid;
   assign out_data    = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_chain.sv
`default_nettype none
// ============================================================================
// tb_pipeline_chain : scoreboard bench for pipeline_chain (DEPTH=5, WIDTH=32)
// Revision: 1.0
// ============================================================================
module tb_pipeline_chain;

   localparam int WIDTH = 32;
   localparam int DEPTH = 5;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic              stall;
   logic [DEPTH-1:0]  flush_mask;
   logic [DEPTH-1:0]  stage_valid;
   logic [2:0]        occupancy;
   logic [CNT_W-1:0]  squash_count;

   pipeline_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .stall        (stall),
      .flush_mask   (flush_mask),
      .stage_valid  (stage_valid),
      .occupancy    (occupancy),
      .squash_count (squash_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int first_acc, first_out, last_out, n_out, peak;
   logic [WIDTH-1:0] sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: push on accepted input, pop and compare on output handshake.
   always @(negedge clk) begin
      if (reset) begin
         if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
            if (first_acc < 0) first_acc = cyc;
         end
         if (out_valid && first_out < 0) first_out = cyc;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
            else check_eq("out_data", out_data, sb_q.pop_front());
            last_out = cyc;
            n_out++;
         end
         if (int'(occupancy) > peak) peak = int'(occupancy);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      logic rdy;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         rdy = in_ready;
         next_cycle();
         if (rdy) begin
            in_valid = 1'b0;
            return;
         end
      end
      check_eq("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      out_ready = 1'b1;
      for (t = 0; t < 60; t++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && occupancy == 0) break;
      end
      check_eq("drain_q", sb_q.size(), 32'd0);
      check_eq("drain_occ", 32'(occupancy), 32'd0);
      next_cycle();
   endtask

   task automatic remove_val(input logic [WIDTH-1:0] v);
      for (int i = 0; i < sb_q.size(); i++) begin
         if (sb_q[i] == v) begin
            sb_q.delete(i);
            return;
         end
      end
      check_eq("sb_remove", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      stall = 1'b0; flush_mask = '0;
      first_acc = -1; first_out = -1; last_out = -1; n_out = 0; peak = 0;
      #12;
      check_eq("rst_stage_valid", 32'(stage_valid), 32'd0);
      check_eq("rst_occupancy", 32'(occupancy), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", out_data, 32'd0);
      check_eq("rst_squash", 32'(squash_count), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      // Streaming 0x1..0xA
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) send(WIDTH'(i));
      drain();
      check_eq("stream_latency", 32'(first_out - first_acc), 32'(DEPTH));
      check_eq("stream_back2back", 32'(last_out - first_out), 32'd9);
      check_eq("stream_count", 32'(n_out), 32'd10);
      check_eq("stream_peak_occ", 32'(peak), 32'd5);

      // Backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(WIDTH'(32'h10 + i));
      in_valid = 1'b1; in_data = 32'h15;
      @(negedge clk);
      check_eq("bp_in_ready_full", 32'(in_ready), 32'd0);
      check_eq("bp_occ_full", 32'(occupancy), 32'd5);
      next_cycle();
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready_drain", 32'(in_ready), 32'd1);
      next_cycle();
      out_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_occ_after", 32'(occupancy), 32'd5);
      check_eq("bp_head", out_data, 32'h11);
      drain();

      // Bubble collapse
      out_ready = 1'b0;
      send(32'hA);
      next_cycle();
      next_cycle();
      send(32'hB);
      repeat (6) next_cycle();
      @(negedge clk);
      check_eq("bubble_stage_valid", 32'(stage_valid), 32'b11000);
      check_eq("bubble_occ", 32'(occupancy), 32'd2);
      drain();

      // Flush stages 1 and 2
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send(WIDTH'(i));
      flush_mask = 5'b00110;
      next_cycle();
      flush_mask = '0;
      remove_val(32'h3);
      remove_val(32'h4);
      @(negedge clk);
      check_eq("flush_squash", 32'(squash_count), 32'd2);
      check_eq("flush_occ", 32'(occupancy), 32'd3);
      check_eq("flush_stage_valid", 32'(stage_valid), 32'b11010);
      drain();

      // Global stall on a full chain
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(WIDTH'(32'h20 + i));
      stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("stall_out_valid", 32'(out_valid), 32'd0);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_stage_valid", 32'(stage_valid), 32'b11111);
         check_eq("stall_head", out_data, 32'h20);
         next_cycle();
      end
      stall = 1'b0; in_valid = 1'b0;
      drain();

      // Asynchronous reset mid-stream
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = WIDTH'(32'h30 + i);
         next_cycle();
      end
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_stage_valid", 32'(stage_valid), 32'd0);
      check_eq("arst_occ", 32'(occupancy), 32'd0);
      check_eq("arst_out_valid", 32'(out_valid), 32'd0);
      check_eq("arst_squash", 32'(squash_count), 32'd0);
      sb_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      next_cycle();
      check_eq("arst_in_ready", 32'(in_ready), 32'd1);
      n_out = 0;
      for (int i = 0; i < 5; i++) send(WIDTH'(32'h40 + i));
      drain();
      check_eq("arst_resume_count", 32'(n_out), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_chain.md
Name: pipeline_chain

Overview:
- Parametrised, elastic successor to the fixed five-stage pipeline register chain.
- Carries a WIDTH-bit payload through DEPTH register stages.
- Per-stage valid bits, valid/ready handshakes on input and output, and a global stall.
- Per-stage selective flush for branch/exception squash, bubble collapsing, live occupancy count, and a saturating squash counter.
- Sits between stage logic blocks as the shared inter-stage register fabric.

Parameters:
- WIDTH, 32: payload bits per stage.
- DEPTH, 5: number of register stages, minimum 1.
- CNT_W, 16: width of the squash counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream offers in_data.
- in_ready, output, 1: chain accepts in_data this cycle.
- in_data, input, WIDTH: payload into stage 0.
- out_valid, output, 1: stage DEPTH-1 holds a live entry.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, WIDTH: payload of stage DEPTH-1.
- stall, input, 1: global hold.
- flush_mask, input, DEPTH: bit i kills the current contents of stage i.
- stage_valid, output, DEPTH: registered valid bit per stage.
- occupancy, output, clog2(DEPTH+1): count of valid stages.
- squash_count, output, CNT_W: saturating count of killed entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valids clear; occupancy=0; squash_count=0.
  - Stage data registers clear to 0, so out_data=0.
  - Hence out_valid=0; in_ready=1 after release unless stall or the stage-0 conditions below apply.
- Effective valid: ve[i] = v[i] & ~flush_mask[i]. A killed entry is a bubble this cycle: it never moves and never produces an output handshake.
- Output side:
  - out_valid = ve[DEPTH-1] & ~stall.
  - Fire: fire_out = out_valid & out_ready.
- Advance rules:
  - adv[DEPTH-1] = fire_out.
  - For i < DEPTH-1: adv[i] = ve[i] & ~stall & (~ve[i+1] | adv[i+1]).
  - Bubbles collapse: a live entry moves into any empty or vacating stage.
- Input side:
  - in_ready = ~stall & (~ve[0] | adv[0]).
  - Accept when in_valid & in_ready; incoming data is never killed by flush_mask[0].
- Next state for stage i:
  - Loads from stage i-1 (or from input when i=0) if that source advances or is accepted; valid=1.
  - Else if ve[i] & ~adv[i]: holds.
  - Else: valid=0. Data is don't-care, but hold it to save power.
- Latency: empty chain with out_ready=1 and no stall gives an entry accepted at edge k, out_valid high after edge k+DEPTH-1, so DEPTH cycles total. Throughput is 1 per cycle.
- Stall: no stage moves and no handshakes occur; valids and data hold, except that flush_mask still kills during stall.
- Occupancy: registered popcount of next-state valids, always equal to popcount(stage_valid).
- Squash counter: squash_count += popcount(flush_mask & v) per cycle, saturating at 2^CNT_W-1, no wrap.
- Simultaneous events:
  - flush of stage i plus an advance from i-1 in the same cycle: stage i receives the younger entry.
  - flush of DEPTH-1 with out_ready=1: no fire.
- A mid-operation reset discards all in-flight entries without counting them as squashes.
- Invariant: once in_data is accepted, its value emerges unchanged and in order, unless killed.

Test Plan:
- Streaming, DEPTH=5, WIDTH=32, out_ready=1, payloads 0x1..0xA on consecutive cycles -> first out_valid 5 cycles after first accept; outputs 0x1..0xA back-to-back; occupancy peaks at 5.
- Backpressure: fill with 0x10..0x14, hold out_ready=0 -> in_ready drops once occupancy=5; raising out_ready for one cycle drains 0x10 and admits one new entry in the same cycle.
- Bubble collapse: feed 0xA, idle 2 cycles, feed 0xB, with out_ready=0 -> 0xB advances until it sits behind 0xA; stage_valid = 5'b11000 (MSB = stage 4).
- Flush: stages hold 0x1..0x5 (0x1 in stage 4), flush_mask=5'b00110 with in_valid=0 -> 0x3 and 0x4 dropped; squash_count=2; next outputs 0x1, 0x2, 0x5.
- Stall: full chain, stall=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, no movement; after release, data resumes unchanged.
- Asynchronous reset asserted mid-stream between clock edges -> stage_valid=0, occupancy=0, out_valid=0 immediately; squash_count=0; normal streaming resumes after release.
